// File: rtl/data_island_packet_scheduler_pkg.sv
// Shared types and constants for the HDMI data-island packet scheduler.
// Packet bundle, slot state encoding and a lowest-set-bit helper.
package hdmi_packet_pkg;

    localparam int PACKET_CYCLES_DEFAULT = 32;
    localparam int NUM_SOURCES_DEFAULT   = 4;

    localparam logic [23:0] NULL_HEADER = 24'h000000;

    typedef struct packed {
        logic [23:0]      header;
        logic [3:0][55:0] sub;
    } packet_t;

    typedef logic [$clog2(NUM_SOURCES_DEFAULT+1)-1:0] src_id_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } slot_state_t;

    // Isolates the lowest set bit (request vectors up to 32 sources).
    function automatic logic [31:0] lowest_set(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/data_island_packet_scheduler_if.sv
// Bundle between packet generators / island timing and the scheduler.
// master drives requests and strobes, slave returns the granted packet.
interface data_island_packet_scheduler_if #(
    parameter int NUM_SOURCES = 4
);
    import hdmi_packet_pkg::*;

    localparam int IDW = $clog2(NUM_SOURCES + 1);

    logic                                frame_start;
    logic [NUM_SOURCES-1:0]              req;
    logic [NUM_SOURCES-1:0][23:0]        src_header;
    logic [NUM_SOURCES-1:0][3:0][55:0]   src_sub;
    logic                                packet_enable;

    logic [23:0]                         header;
    logic [3:0][55:0]                    sub;
    logic [IDW-1:0]                      grant_id;
    logic [NUM_SOURCES-1:0]              ack;
    logic                                busy;
    logic                                overlap_err;

    modport master (
        output frame_start, req, src_header, src_sub, packet_enable,
        input  header, sub, grant_id, ack, busy, overlap_err
    );

    modport slave (
        input  frame_start, req, src_header, src_sub, packet_enable,
        output header, sub, grant_id, ack, busy, overlap_err
    );

endinterface

// File: rtl/data_island_packet_scheduler_rr_arbiter.sv
// Masked-priority round-robin over sources FIXED_COUNT..NUM_SOURCES-1.
// Sources at or above rr_ptr win first; otherwise wrap to the lowest.
module packet_rr_arbiter
    import hdmi_packet_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int FIXED_COUNT = 1,
    parameter int PW          = 2
) (
    input  logic [NUM_SOURCES-1:0] pending,
    input  logic [PW-1:0]          rr_ptr,
    output logic [NUM_SOURCES-1:0] grant,
    output logic                   valid
);

    logic [NUM_SOURCES-1:0] rr_req;
    logic [NUM_SOURCES-1:0] hi_req;

    // Split round-robin requests into those at/above the pointer and all.
    always_comb begin
        rr_req = '0;
        hi_req = '0;
        for (int i = FIXED_COUNT; i < NUM_SOURCES; i++) begin
            rr_req[i] = pending[i];
            hi_req[i] = pending[i] && (PW'(i) >= rr_ptr);
        end
        if (|hi_req) begin
            grant = NUM_SOURCES'(lowest_set(32'(hi_req)));
        end else begin
            grant = NUM_SOURCES'(lowest_set(32'(rr_req)));
        end
        valid = |rr_req;
    end

endmodule

// File: rtl/data_island_packet_scheduler.sv
// Grants the single data-island packet slot to one pending source per
// packet_enable strobe, holding the packet for PACKET_CYCLES pixel clocks.
module data_island_packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int                     NUM_SOURCES   = 4,
    parameter int                     FIXED_COUNT   = 1,
    parameter logic [NUM_SOURCES-1:0] FRAME_MASK    = 4'b1100,
    parameter int                     PACKET_CYCLES = PACKET_CYCLES_DEFAULT
) (
    input  logic                          clk_pixel,
    input  logic                          reset_n,
    data_island_packet_scheduler_if.slave bus
);

    localparam int IDW = $clog2(NUM_SOURCES + 1);
    localparam int PW  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int CW  = (PACKET_CYCLES > 1) ? $clog2(PACKET_CYCLES) : 1;

    slot_state_t            state;
    logic [NUM_SOURCES-1:0] pending;
    logic [PW-1:0]          rr_ptr;
    logic [CW-1:0]          cnt;
    logic                   ovl_q;
    packet_t                pkt_q;
    logic [IDW-1:0]         gid_q;
    logic [NUM_SOURCES-1:0] ack_q;

    logic [NUM_SOURCES-1:0] fix_req;
    logic [NUM_SOURCES-1:0] fix_oh;
    logic [NUM_SOURCES-1:0] rr_oh;
    logic                   rr_valid;
    logic [NUM_SOURCES-1:0] win_oh;
    logic                   win_is_rr;
    logic [IDW-1:0]         win_id;
    packet_t                win_pkt;
    logic [PW-1:0]          nxt_ptr;
    logic                   fire;

    packet_rr_arbiter #(
        .NUM_SOURCES (NUM_SOURCES),
        .FIXED_COUNT (FIXED_COUNT),
        .PW          (PW)
    ) u_rr (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .grant   (rr_oh),
        .valid   (rr_valid)
    );

    // Strict priority below FIXED_COUNT, round-robin above, else Null.
    always_comb begin
        fix_req = '0;
        for (int i = 0; i < FIXED_COUNT; i++) begin
            fix_req[i] = pending[i];
        end
        fix_oh    = NUM_SOURCES'(lowest_set(32'(fix_req)));
        win_is_rr = !(|fix_req) && rr_valid;
        if (|fix_req) begin
            win_oh = fix_oh;
        end else if (rr_valid) begin
            win_oh = rr_oh;
        end else begin
            win_oh = '0;
        end
    end

    // Winner index, its packet contents and the advanced rr pointer.
    always_comb begin
        win_id         = IDW'(NUM_SOURCES);
        win_pkt.header = NULL_HEADER;
        win_pkt.sub    = '0;
        nxt_ptr        = rr_ptr;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (win_oh[i]) begin
                win_id         = IDW'(i);
                win_pkt.header = bus.src_header[i];
                win_pkt.sub    = bus.src_sub[i];
            end
        end
        for (int i = FIXED_COUNT; i < NUM_SOURCES; i++) begin
            if (win_is_rr && win_oh[i]) begin
                nxt_ptr = (i == NUM_SOURCES - 1) ? PW'(FIXED_COUNT)
                                                 : PW'(i + 1);
            end
        end
    end

    assign fire = bus.packet_enable && (state == ST_IDLE);

    // Pending flags, slot FSM/counter and registered packet outputs.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            pending <= '0;
            rr_ptr  <= PW'(FIXED_COUNT);
            cnt     <= '0;
            ovl_q   <= 1'b0;
            pkt_q   <= '0;
            gid_q   <= IDW'(NUM_SOURCES);
            ack_q   <= '0;
        end else begin
            // Clear of the granted source first, so a same-cycle
            // re-request survives.
            pending <= (pending & ~(fire ? win_oh : '0))
                     | bus.req
                     | (bus.frame_start ? FRAME_MASK : '0);
            ack_q   <= fire ? win_oh : '0;
            if (bus.packet_enable && (state == ST_SLOT)) begin
                ovl_q <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (fire) begin
                        state  <= ST_SLOT;
                        cnt    <= '0;
                        pkt_q  <= win_pkt;
                        gid_q  <= win_id;
                        rr_ptr <= nxt_ptr;
                    end
                end
                ST_SLOT: begin
                    if (cnt == CW'(PACKET_CYCLES - 1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.header      = pkt_q.header;
    assign bus.sub         = pkt_q.sub;
    assign bus.grant_id    = gid_q;
    assign bus.ack         = ack_q;
    assign bus.busy        = (state == ST_SLOT);
    assign bus.overlap_err = ovl_q;

endmodule

// File: tb/tb_data_island_packet_scheduler.sv
// Bench for data_island_packet_scheduler: directed scenarios plus a
// randomized run against a slot-level reference model.
module tb_data_island_packet_scheduler;
    import hdmi_packet_pkg::*;

    localparam int NS = 4;
    localparam int FC = 1;
    localparam int PC = 32;
    localparam logic [NS-1:0] FMASK = 4'b1100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    data_island_packet_scheduler_if #(.NUM_SOURCES(NS)) bus ();

    data_island_packet_scheduler #(
        .NUM_SOURCES   (NS),
        .FIXED_COUNT   (FC),
        .FRAME_MASK    (FMASK),
        .PACKET_CYCLES (PC)
    ) dut (
        .clk_pixel (clk),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [NS-1:0]      m_pend;
    int               m_rr;
    int               m_left;
    logic [23:0]      m_hdr;
    logic [3:0][55:0] m_sub;
    int               m_gid;
    logic [NS-1:0]    m_ack;
    bit               m_ovl;

    function automatic int pick(bit [NS-1:0] p, int rr);
        for (int i = 0; i < FC; i++) if (p[i]) return i;
        for (int s = 0; s < NS - FC; s++) begin
            int idx;
            idx = FC + ((rr - FC + s) % (NS - FC));
            if (p[idx]) return idx;
        end
        return NS;
    endfunction

    task automatic model_edge();
        bit was_busy;
        int w;
        if (!reset_n) begin
            m_pend = '0; m_rr = FC; m_left = 0;
            m_hdr = '0; m_sub = '0; m_gid = NS; m_ack = '0; m_ovl = 0;
        end else begin
            was_busy = (m_left > 0);
            m_ack = '0;
            if (bus.packet_enable && was_busy) m_ovl = 1;
            if (bus.packet_enable && !was_busy) begin
                w = pick(m_pend, m_rr);
                m_gid = w;
                m_left = PC;
                if (w < NS) begin
                    m_hdr = bus.src_header[w];
                    m_sub = bus.src_sub[w];
                    m_ack[w] = 1'b1;
                    m_pend[w] = 1'b0;
                    if (w >= FC) m_rr = (w == NS - 1) ? FC : w + 1;
                end else begin
                    m_hdr = '0;
                    m_sub = '0;
                end
            end else if (was_busy) begin
                m_left--;
            end
            m_pend |= bus.req | (bus.frame_start ? FMASK : '0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        bus.req = '0;
        bus.frame_start = 1'b0;
        bus.packet_enable = 1'b0;
    endtask

    task automatic rand_srcs();
        logic [63:0] t;
        for (int i = 0; i < NS; i++) begin
            bus.src_header[i] = 24'($urandom);
            for (int j = 0; j < 4; j++) begin
                t = {$urandom, $urandom};
                bus.src_sub[i][j] = t[55:0];
            end
        end
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic wait_idle();
        set_idle();
        for (int k = 0; k < PC + 4 && m_left > 0; k++) cycle();
    endtask

    task automatic strobe();
        bus.packet_enable = 1'b1;
        cycle();
        bus.packet_enable = 1'b0;
    endtask

    task automatic test_reset();
        rand_srcs();
        reset_n = 1'b0;
        bus.req = '1;
        bus.frame_start = 1'b1;
        bus.packet_enable = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.grant_id !== 3'd4) begin
            n_fail++; $display("FAIL reset_gid: got %0d want 4", bus.grant_id);
        end
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.overlap_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ack_ovl: got %b/%b want 0000/0",
                     bus.ack, bus.overlap_err);
        end
        n_checks++;
        if (bus.header !== 24'h0 || bus.sub !== '0) begin
            n_fail++; $display("FAIL reset_pkt: got %h want 0", bus.header);
        end
        set_idle();
        reset_n = 1'b1;
    endtask

    task automatic test_null_slot();
        int hi;
        do_reset();
        repeat (8) cycle();
        strobe();
        n_checks++;
        if (bus.grant_id !== 3'd4 || bus.header !== 24'h0 ||
            bus.ack !== 4'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL null_grant: got gid=%0d hdr=%h ack=%b busy=%b want 4/0/0/1",
                     bus.grant_id, bus.header, bus.ack, bus.busy);
        end
        hi = 0;
        repeat (PC - 1) begin
            cycle();
            if (bus.busy === 1'b1) hi++;
        end
        n_checks++;
        if (hi !== PC - 1) begin
            n_fail++; $display("FAIL null_busy_len: got %0d want %0d", hi, PC - 1);
        end
        cycle();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL null_busy_fall: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_fixed_priority();
        logic [23:0] h0, h2;
        do_reset();
        rand_srcs();
        h0 = bus.src_header[0];
        h2 = bus.src_header[2];
        bus.req = 4'b0101;
        cycle();
        bus.req = '0;
        repeat (4) cycle();
        strobe();
        n_checks++;
        if (bus.grant_id !== 3'd0 || bus.ack !== 4'b0001 || bus.header !== h0) begin
            n_fail++;
            $display("FAIL fixed_first: got gid=%0d ack=%b hdr=%h want 0/0001/%h",
                     bus.grant_id, bus.ack, bus.header, h0);
        end
        cycle();
        n_checks++;
        if (bus.ack !== 4'b0000) begin
            n_fail++; $display("FAIL ack_pulse: got %b want 0000", bus.ack);
        end
        wait_idle();
        strobe();
        n_checks++;
        if (bus.grant_id !== 3'd2 || bus.ack !== 4'b0100 || bus.header !== h2) begin
            n_fail++;
            $display("FAIL rr_second: got gid=%0d ack=%b hdr=%h want 2/0100/%h",
                     bus.grant_id, bus.ack, bus.header, h2);
        end
    endtask

    task automatic test_frame_refresh();
        int          exp_id  [3] = '{2, 3, 4};
        logic [23:0] exp_hdr [3] = '{24'h0D0282, 24'h190183, 24'h000000};
        do_reset();
        rand_srcs();
        bus.src_header[2] = 24'h0D0282;
        bus.src_header[3] = 24'h190183;
        bus.frame_start = 1'b1;
        cycle();
        bus.frame_start = 1'b0;
        repeat (4) cycle();
        for (int k = 0; k < 3; k++) begin
            strobe();
            n_checks++;
            if (bus.grant_id !== 3'(exp_id[k]) || bus.header !== exp_hdr[k]) begin
                n_fail++;
                $display("FAIL frame_order[%0d]: got gid=%0d hdr=%h want %0d/%h",
                         k, bus.grant_id, bus.header, exp_id[k], exp_hdr[k]);
            end
            wait_idle();
        end
        bus.req = 4'b1010;
        cycle();
        bus.req = '0;
        strobe();
        n_checks++;
        if (bus.grant_id !== 3'd1) begin
            n_fail++; $display("FAIL rr_wrap: got gid=%0d want 1", bus.grant_id);
        end
    endtask

    task automatic test_rerequest();
        do_reset();
        rand_srcs();
        bus.req = 4'b0100;
        cycle();
        bus.packet_enable = 1'b1;
        cycle();
        set_idle();
        n_checks++;
        if (bus.grant_id !== 3'd2 || bus.ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL rereq_first: got gid=%0d ack=%b want 2/0100",
                     bus.grant_id, bus.ack);
        end
        wait_idle();
        strobe();
        n_checks++;
        if (bus.grant_id !== 3'd2 || bus.ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL rereq_again: got gid=%0d ack=%b want 2/0100",
                     bus.grant_id, bus.ack);
        end
    endtask

    task automatic test_overlap();
        logic [23:0] h0;
        do_reset();
        rand_srcs();
        h0 = bus.src_header[0];
        bus.req = 4'b0001;
        cycle();
        bus.req = '0;
        strobe();
        n_checks++;
        if (bus.overlap_err !== 1'b0 || bus.grant_id !== 3'd0) begin
            n_fail++;
            $display("FAIL ovl_pre: got ovl=%b gid=%0d want 0/0",
                     bus.overlap_err, bus.grant_id);
        end
        bus.req = 4'b0100;
        cycle();
        bus.req = '0;
        repeat (7) cycle();
        rand_srcs();
        strobe();
        n_checks++;
        if (bus.header !== h0 || bus.grant_id !== 3'd0 ||
            bus.ack !== 4'b0 || bus.overlap_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovl_ignored: got hdr=%h gid=%0d ack=%b ovl=%b want %h/0/0000/1",
                     bus.header, bus.grant_id, bus.ack, bus.overlap_err, h0);
        end
        wait_idle();
        strobe();
        n_checks++;
        if (bus.grant_id !== 3'd2 || bus.overlap_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovl_sticky: got gid=%0d ovl=%b want 2/1",
                     bus.grant_id, bus.overlap_err);
        end
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        n_checks++;
        if (bus.overlap_err !== 1'b0) begin
            n_fail++; $display("FAIL ovl_clear: got %b want 0", bus.overlap_err);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        rand_srcs();
        bus.src_header[1] = 24'hA5A501;
        bus.req = 4'b0010;
        cycle();
        bus.req = '0;
        strobe();
        n_checks++;
        if (bus.grant_id !== 3'd1 || bus.header !== 24'hA5A501) begin
            n_fail++;
            $display("FAIL mid_pre: got gid=%0d hdr=%h want 1/a5a501",
                     bus.grant_id, bus.header);
        end
        repeat (5) cycle();
        bus.req = 4'b1000;
        cycle();
        bus.req = '0;
        repeat (3) cycle();
        reset_n = 1'b0;
        cycle();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.header !== 24'h0 ||
            bus.sub !== '0 || bus.grant_id !== 3'd4) begin
            n_fail++;
            $display("FAIL mid_abort: got busy=%b hdr=%h gid=%0d want 0/0/4",
                     bus.busy, bus.header, bus.grant_id);
        end
        reset_n = 1'b1;
        cycle();
        strobe();
        n_checks++;
        if (bus.grant_id !== 3'd4 || bus.ack !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_post_null: got gid=%0d ack=%b want 4/0000",
                     bus.grant_id, bus.ack);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            reset_n = ($urandom_range(0, 599) != 0);
            bus.frame_start = ($urandom_range(0, 63) == 0);
            bus.packet_enable = ($urandom_range(0, 23) == 0);
            for (int i = 0; i < NS; i++) bus.req[i] = ($urandom_range(0, 15) == 0);
            rand_srcs();
            cycle();
            n_checks++;
            if (bus.header !== m_hdr || bus.sub !== m_sub) begin
                n_fail++;
                $display("FAIL rnd_pkt @%0d: got hdr=%h want %h", n, bus.header, m_hdr);
            end
            n_checks++;
            if (bus.grant_id !== 3'(m_gid) || bus.ack !== m_ack) begin
                n_fail++;
                $display("FAIL rnd_grant @%0d: got gid=%0d ack=%b want %0d/%b",
                         n, bus.grant_id, bus.ack, m_gid, m_ack);
            end
            n_checks++;
            if (bus.busy !== (m_left > 0) || bus.overlap_err !== m_ovl) begin
                n_fail++;
                $display("FAIL rnd_status @%0d: got busy=%b ovl=%b want %b/%b",
                         n, bus.busy, bus.overlap_err, (m_left > 0), m_ovl);
            end
        end
        reset_n = 1'b1;
        set_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_idle();
        bus.src_header = '0;
        bus.src_sub = '0;
        m_pend = '0; m_rr = FC; m_left = 0; m_hdr = '0; m_sub = '0;
        m_gid = NS; m_ack = '0; m_ovl = 0;
        #1;
        test_reset();
        test_null_slot();
        test_fixed_priority();
        test_frame_refresh();
        test_rerequest();
        test_overlap();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_island_packet_scheduler.md
Name: data_island_packet_scheduler

Overview:
- Shares the single HDMI data-island packet slot between NUM_SOURCES packet generators: audio sample, audio clock regeneration, and the AVI/SPD/audio InfoFrames.
- Tracks a pending flag per source and grants one source per packet_enable strobe from the island timing logic.
- Latches the granted header/subpackets for the packet duration, and emits a Null packet when nothing is pending.
- Sits between the InfoFrame/audio packet modules and the data-island TERC4 packet assembler.

Parameters:
- NUM_SOURCES, 4, number of requesters (index 0..NUM_SOURCES-1).
- FIXED_COUNT, 1, sources 0..FIXED_COUNT-1 use strict priority (lower index wins); the remaining sources use round-robin.
- FRAME_MASK, 4'b1100, bit i set => source i pending is set on every frame_start (InfoFrame refresh).
- PACKET_CYCLES, 32, pixel clocks per packet.

Ports:
- clk_pixel  in  1  pixel clock
- reset_n  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of frame
- req  in  NUM_SOURCES  per-source request; level sampled each cycle
- src_header  in  [NUM_SOURCES] x 24  per-source packet header
- src_sub  in  [NUM_SOURCES] x [4] x 56  per-source subpackets
- packet_enable  in  1  one-cycle pulse: a packet slot begins
- header  out  24  granted header
- sub  out  [4] x 56  granted subpackets
- grant_id  out  $clog2(NUM_SOURCES+1)  granted index; NUM_SOURCES = Null
- ack  out  NUM_SOURCES  one-hot, one-cycle pulse to the granted source
- busy  out  1  packet slot in progress
- overlap_err  out  1  sticky: packet_enable arrived while busy

Behaviour:
- Reset (reset_n=0 at a clk_pixel edge):
  - pending=0, rr_ptr=FIXED_COUNT, header=0, sub=0.
  - grant_id=NUM_SOURCES, ack=0, busy=0, overlap_err=0, slot counter=0.
  - Reset asserted mid-packet aborts the packet; outputs reach reset values at the same edge.
- Pending update, every cycle:
  - Set term: pending_next[i] = pending[i] | req[i] | (frame_start & FRAME_MASK[i]).
  - Grant clear is applied before the set term. If a source is granted and its req or frame_start hits in the same cycle, pending stays 1 and the new request is not lost.
- Grant on cycle t: packet_enable=1 and busy=0.
  - Winner is the lowest-index pending source below FIXED_COUNT.
  - Otherwise, the first pending source >= FIXED_COUNT searching from rr_ptr upward with wrap back to FIXED_COUNT.
  - Otherwise Null.
  - Arbitration uses pending as registered at t; requests arriving in cycle t are not eligible until the next slot.
  - src_header/src_sub of the winner are sampled at edge t.
  - At t+1: header/sub/grant_id are valid, ack[winner] pulses for one cycle, busy=1.
  - Null grant: header=24'h000000, sub all zero, grant_id=NUM_SOURCES, ack=0.
  - Round-robin grant of source k: rr_ptr = k+1, wrapping to FIXED_COUNT after NUM_SOURCES-1. Fixed or Null grants leave rr_ptr unchanged.
- Slot timing:
  - Counter runs 0..PACKET_CYCLES-1 starting at t+1.
  - busy is high for exactly PACKET_CYCLES cycles (t+1..t+PACKET_CYCLES) and falls after the last count.
  - header/sub/grant_id hold their value until the next grant; they do not change mid-packet.
  - packet_enable in the cycle after busy falls is a legal new grant.
- Overlap:
  - packet_enable while busy=1 is ignored: no grant, no pending change.
  - overlap_err sets on the following edge and stays set until reset.
- packet_enable and frame_start in the same cycle: the grant uses the old pending; the FRAME_MASK sources become pending for the next slot.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package hdmi_packet_pkg holds:
  - PACKET_CYCLES_DEFAULT = 32
  - NULL_HEADER = 24'h000000
  - typedef packet_t: struct { header[23:0]; sub[3:0][55:0] }
  - typedef src_id_t sized from NUM_SOURCES
- One sub-module, packet_rr_arbiter: combinational masked-priority round-robin over sources FIXED_COUNT..NUM_SOURCES-1. Inputs are pending and rr_ptr; outputs are a one-hot grant and a valid flag.
- The scheduler owns the pending, pointer, counter and output registers.

Test Plan:
- Reset release, no requests, packet_enable at cycle 10 -> at cycle 11: grant_id=4, header=0, ack=0, busy=1. busy=0 at cycle 43.
- req[0] and req[2] pulsed at cycle 5, packet_enable at 10 -> grant_id=0, ack=4'b0001 at 11. Next packet_enable at 44 -> grant_id=2, header=src_header[2].
- frame_start at 5, src_header[2]=24'h0D0282, src_header[3]=24'h190183, three packet_enable at 10/44/78 -> grant order 2, 3, Null. rr_ptr=1 after the second grant (wrap).
- Source 2 pending, req[2]=1 in the cycle of its grant -> ack[2] pulses; the next slot grants 2 again.
- packet_enable at 10 and again at 20 -> second strobe ignored, header unchanged, overlap_err=1 from 21 until reset_n=0.
- reset_n=0 at cycle 25 during a packet -> busy=0, header=0, pending=0 at that edge. A post-reset packet_enable grants Null.
